// File: rtl/reg_seq_pkg.sv
// Shared types and the ALU evaluation function for the reg_bank sequencer.
// Pure declarations and combinational helpers; no latency, no flow control.
package reg_seq_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SHL = 3'd5,
        OP_MOV = 3'd6,
        OP_LDI = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_t;

    localparam int ALU_MAXW = 32;
    typedef logic [ALU_MAXW-1:0] alu_word_t;

    // Operands arrive zero-extended to ALU_MAXW; w is the live word width (power of two, < ALU_MAXW).
    function automatic logic [ALU_MAXW:0] alu_eval(op_t op, alu_word_t a, alu_word_t b,
                                                   alu_word_t imm, int unsigned w);
        logic [2*ALU_MAXW-1:0] wide;
        alu_word_t             mask;
        alu_word_t             res;
        int unsigned           amt;
        logic                  carry;
        mask  = (alu_word_t'(1) << w) - alu_word_t'(1);
        amt   = b & alu_word_t'(w - 1);
        wide  = '0;
        res   = '0;
        carry = 1'b0;
        case (op)
            OP_ADD: begin
                wide = {{ALU_MAXW{1'b0}}, a} + {{ALU_MAXW{1'b0}}, b};
                res  = wide[ALU_MAXW-1:0];
            end
            OP_SUB: begin
                res   = a - b;
                carry = (a < b);
            end
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_XOR: res = a ^ b;
            OP_SHL: begin
                wide = {{ALU_MAXW{1'b0}}, a} << amt;
                res  = wide[ALU_MAXW-1:0];
            end
            OP_MOV: res = a;
            OP_LDI: res = imm;
            default: res = '0;
        endcase
        // Bit w of the widened value is the ADD carry-out or the last bit shifted out by SHL.
        if (op == OP_ADD || op == OP_SHL) begin
            wide  = wide >> w;
            carry = wide[0];
        end
        return {carry, res & mask};
    endfunction

endpackage

// File: rtl/reg_seq_alu.sv
// Combinational W-bit ALU wrapper around alu_eval.
// Zero latency, no flow control; result and carry follow the inputs.
module reg_seq_alu
    import reg_seq_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [2:0]   op_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] imm_i,
    output logic [W-1:0] res_o,
    output logic         carry_o
);

    logic [ALU_MAXW:0] eval;
    logic              unused_ok;

    assign eval      = alu_eval(op_t'(op_i), alu_word_t'(a_i), alu_word_t'(b_i),
                                alu_word_t'(imm_i), W);
    assign res_o     = eval[W-1:0];
    assign carry_o   = eval[ALU_MAXW];
    assign unused_ok = &{1'b0, eval[ALU_MAXW-1:W]};

endmodule

// File: rtl/reg_bank_sequencer.sv
// Four-state READ/EXEC/WB sequencer driving reg_bank; one instruction per 4 cycles.
// instr_ready is high only in IDLE; offers made in other states are ignored until then.
module reg_bank_sequencer
    import reg_seq_pkg::*;
#(
    parameter int W = 16,
    parameter int N = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         instr_valid,
    output logic         instr_ready,
    input  logic [2:0]   op,
    input  logic [N-1:0] rd,
    input  logic [N-1:0] rs1_sel,
    input  logic [N-1:0] rs2_sel,
    input  logic [W-1:0] imm,
    output logic         bank_we,
    output logic [N-1:0] bank_addr_rd,
    output logic [N-1:0] bank_addr_rs1,
    output logic [N-1:0] bank_addr_rs2,
    output logic [W-1:0] bank_data_in,
    input  logic [W-1:0] bank_rs1,
    input  logic [W-1:0] bank_rs2,
    output logic         done,
    output logic [W-1:0] result,
    output logic         flag_zero,
    output logic         flag_carry
);

    state_t       state_q;
    logic [2:0]   op_q;
    logic [N-1:0] rd_q;
    logic [W-1:0] imm_q;
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;

    logic         ready_q;
    logic         we_q;
    logic         done_q;
    logic [N-1:0] addr_rd_q;
    logic [N-1:0] addr_rs1_q;
    logic [N-1:0] addr_rs2_q;
    logic [W-1:0] data_in_q;
    logic [W-1:0] result_q;
    logic         zero_q;
    logic         carry_q;

    logic [W-1:0] alu_res;
    logic         alu_carry;

    reg_seq_alu #(.W(W)) u_alu (
        .op_i    (op_q),
        .a_i     (a_q),
        .b_i     (b_q),
        .imm_i   (imm_q),
        .res_o   (alu_res),
        .carry_o (alu_carry)
    );

    // Reset clears bank_we asynchronously, so an interrupted WB never writes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            op_q       <= '0;
            rd_q       <= '0;
            imm_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            ready_q    <= 1'b1;
            we_q       <= 1'b0;
            done_q     <= 1'b0;
            addr_rd_q  <= '0;
            addr_rs1_q <= '0;
            addr_rs2_q <= '0;
            data_in_q  <= '0;
            result_q   <= '0;
            zero_q     <= 1'b0;
            carry_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (instr_valid && ready_q) begin
                        op_q       <= op;
                        rd_q       <= rd;
                        imm_q      <= imm;
                        addr_rs1_q <= rs1_sel;
                        addr_rs2_q <= rs2_sel;
                        ready_q    <= 1'b0;
                        state_q    <= ST_READ;
                    end
                end
                ST_READ: begin
                    a_q     <= bank_rs1;
                    b_q     <= bank_rs2;
                    state_q <= ST_EXEC;
                end
                ST_EXEC: begin
                    result_q  <= alu_res;
                    zero_q    <= (alu_res == '0);
                    carry_q   <= alu_carry;
                    we_q      <= 1'b1;
                    done_q    <= 1'b1;
                    addr_rd_q <= rd_q;
                    data_in_q <= alu_res;
                    state_q   <= ST_WB;
                end
                ST_WB: begin
                    we_q    <= 1'b0;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign instr_ready   = ready_q;
    assign bank_we       = we_q;
    assign bank_addr_rd  = addr_rd_q;
    assign bank_addr_rs1 = addr_rs1_q;
    assign bank_addr_rs2 = addr_rs2_q;
    assign bank_data_in  = data_in_q;
    assign done          = done_q;
    assign result        = result_q;
    assign flag_zero     = zero_q;
    assign flag_carry    = carry_q;

endmodule

// File: doc/reg_bank_sequencer.md
Name: reg_bank_sequencer

Overview:
- Upstream control stage for reg_bank: accepts one ALU instruction at a time over a valid/ready handshake.
- Reads both source operands from the bank and computes the result, then writes it back through the bank's write port.
- Owns every bank control input (we, addr_rd, addr_rs1, addr_rs2, data_in) and consumes rs1/rs2.
- Fixed 4-state FSM, one instruction per 4 cycles, with status flags for the host.

Parameters:
- W, 16, data word width (matches reg_bank W)
- N, 5, register address width; 2**N registers

Ports:
- clk  input  1  system clock, rising-edge
- reset  input  1  asynchronous, active-high reset
- instr_valid  input  1  instruction offered
- instr_ready  output  1  sequencer can accept an instruction (IDLE only)
- op  input  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 MOV, 7 LDI
- rd  input  N  destination register
- rs1_sel  input  N  source register 1
- rs2_sel  input  N  source register 2
- imm  input  W  immediate, used by LDI only
- bank_we  output  1  to reg_bank we
- bank_addr_rd  output  N  to reg_bank addr_rd
- bank_addr_rs1  output  N  to reg_bank addr_rs1
- bank_addr_rs2  output  N  to reg_bank addr_rs2
- bank_data_in  output  W  to reg_bank data_in
- bank_rs1  input  W  from reg_bank rs1
- bank_rs2  input  W  from reg_bank rs2
- done  output  1  one-cycle pulse, coincident with the write-back cycle
- result  output  W  last computed result, held until the next EXEC
- flag_zero  output  1  result == 0, registered with result
- flag_carry  output  1  ADD carry-out / SUB borrow / SHL last bit shifted out; 0 for other ops

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE; all outputs 0 except instr_ready=1.
  - bank_we drops immediately, even mid-instruction.
  - The captured instruction is discarded; no partial write.
- Accept: instr_valid && instr_ready at rising edge k captures op/rd/rs1_sel/rs2_sel/imm into internal registers.
- States and transitions:
  - IDLE: instr_ready=1. On accept goes to READ.
  - READ (cycle k+1): bank_addr_rs1/rs2 driven from the captured selects; bank_rs1/bank_rs2 registered at the end of the cycle. Goes to EXEC.
  - EXEC (cycle k+2): registers result and flags from the latched operands. Goes to WB.
  - WB (cycle k+3): bank_we=1, bank_addr_rd=captured rd, bank_data_in=result, done=1. Goes to IDLE.
- Timing:
  - instr_ready=0 in READ/EXEC/WB. Next accept is possible at edge k+4, so a back-to-back throughput of 1 instruction per 4 cycles.
  - instr_valid in non-IDLE states is ignored; the producer must hold it.
- Arithmetic (W-bit, wrap-around):
  - ADD: {carry,res} = a+b.
  - SUB: res = a-b, carry = (a<b).
  - SHL: res = a << b[$clog2(W)-1:0], carry = last bit shifted out; shift amount 0 gives carry=0.
  - MOV: res = a.
  - LDI: res = imm; operands are read but ignored.
- Read-after-write: an instruction reading the rd written by the previous instruction must see the new value. The bank write at k+3 lands before the next READ at k+5 or later, so no forwarding is required.
- rd=0 is written like any other register; the sequencer applies no special-casing.
- bank_addr_* and bank_data_in hold their last values outside their active states; bank_we is 1 only in WB.

Decomposition:
- Package reg_seq_pkg holds:
  - op_t enum (ADD..LDI, 3 bits)
  - state_t enum (IDLE, READ, EXEC, WB)
  - function alu_eval(op, a, b, imm) returning {carry, result}
- One natural sub-module, reg_seq_alu: purely combinational, wraps alu_eval. The FSM and registers stay in the top module.

Test Plan:
- Pulse reset during WB of an LDI r3,0x1234 -> bank_we falls without waiting for a clock edge, state IDLE, instr_ready=1; r3 keeps its previous value.
- LDI r1,0x00FF accepted at edge k -> bank_we=1, addr_rd=1, data_in=0x00FF in cycle k+3; done pulses once; flag_zero=0.
- With r1=0xFFFF, r2=0x0001, ADD r4,r1,r2 -> result=0x0000, flag_zero=1, flag_carry=1, r4=0x0000.
- SUB r5,r2,r1 (1-0xFFFF) -> result=0x0002, flag_carry=1; then SHL r6,r1,r2 -> result=0xFFFE, carry=1.
- Back-to-back chain with instr_valid held high: LDI r7,5; ADD r7,r7,r7; ADD r7,r7,r7 -> accepts spaced exactly 4 cycles apart; r7 ends at 20, so the read-after-write hazard is correct.
- Apply instr_valid=1 during EXEC with no accept in IDLE -> no capture; the in-flight instruction is unaffected and the offered instruction is accepted at the next IDLE edge.
